fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fd_pipe_reg.sv | 39 +++
 rtl/fetch_stage.sv | 93 +++++++++
 tb/tb_fetch_stage.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [63:0] NOP_INSTR        = 64'h0;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fd_pipe_reg.sv
// Fetch/Decode pipeline register: synchronous reset, clear loads a bubble, enable captures.
module fd_pipe_reg
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_instr,
  input  logic [WIDTH-1:0] i_pcplus8,
  output logic [WIDTH-1:0] o_instr,
  output logic [WIDTH-1:0] o_pcplus8,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_pcplus8;
  logic             r_valid;

  // Clear beats enable so a flush lands even while Decode is stalled.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_instr   <= WIDTH'(NOP_INSTR);
      r_pcplus8 <= '0;
      r_valid   <= 1'b0;
    end else if (i_en) begin
      r_instr   <= i_instr;
      r_pcplus8 <= i_pcplus8;
      r_valid   <= 1'b1;
    end
  end

  assign o_instr   = r_instr;
  assign o_pcplus8 = r_pcplus8;
  assign o_valid   = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection, RUN/WAIT memory FSM, F/D register.
// Handshake: a fetch is accepted only in a cycle where imem_ready=1 and nothing stalls or redirects.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 64,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             BranchTakenE,
  input  logic [WIDTH-1:0] BranchTargetE,
  input  logic             PCSrcW,
  input  logic [WIDTH-1:0] ResultW,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             imem_ready,
  output logic [WIDTH-1:0] PCF,
  output logic [WIDTH-1:0] InstructionD,
  output logic [WIDTH-1:0] PCPlus8D,
  output logic             ValidD,
  output fetch_state_t     o_state
);

  logic [WIDTH-1:0] r_pc;
  fetch_state_t     r_state;

  logic             w_redirect;
  logic             w_accept;
  logic [WIDTH-1:0] w_pc_plus8;
  logic [WIDTH-1:0] w_pc_next;
  fetch_state_t     w_state_next;
  logic             w_fd_en;
  logic             w_fd_clr;

  assign w_redirect = BranchTakenE | PCSrcW;
  assign w_accept   = imem_ready & ~StallF & ~w_redirect;
  assign w_pc_plus8 = r_pc + WIDTH'(8);

  // Execute redirect outranks Writeback redirect; both outrank stalls and memory wait.
  always_comb begin
    w_pc_next = r_pc;
    if (BranchTakenE)                w_pc_next = BranchTargetE;
    else if (PCSrcW)                 w_pc_next = ResultW;
    else if (StallF || !imem_ready)  w_pc_next = r_pc;
    else                             w_pc_next = w_pc_plus8;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (!imem_ready && !w_redirect) w_state_next = WAIT;
      WAIT:    if (imem_ready || w_redirect)   w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_state <= RUN;
    end else begin
      r_pc    <= w_pc_next;
      r_state <= w_state_next;
    end
  end

  // Without a stall, D captures an accepted fetch or else takes a bubble.
  assign w_fd_clr = FlushD | (~StallD & ~w_accept);
  assign w_fd_en  = ~StallD & w_accept;

  fd_pipe_reg #(
    .WIDTH(WIDTH)
  ) u_fd_pipe_reg (
    .clk       (clk),
    .reset     (reset),
    .i_en      (w_fd_en),
    .i_clr     (w_fd_clr),
    .i_instr   (imem_rdata),
    .i_pcplus8 (w_pc_plus8),
    .o_instr   (InstructionD),
    .o_pcplus8 (PCPlus8D),
    .o_valid   (ValidD)
  );

  assign imem_addr = r_pc;
  assign PCF       = r_pc;
  assign o_state   = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns {32'hDEADBEEF, addr[31:0]}.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         StallF, StallD, FlushD;
  logic         BranchTakenE, PCSrcW;
  logic [W-1:0] BranchTargetE, ResultW;
  logic [W-1:0] imem_addr, imem_rdata;
  logic         imem_ready;
  logic [W-1:0] PCF, InstructionD, PCPlus8D;
  logic         ValidD;
  fetch_state_t o_state;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign imem_rdata = {32'hDEAD_BEEF, imem_addr[31:0]};

  fetch_stage #(.WIDTH(W), .RESET_PC(64'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .StallF        (StallF),
    .StallD        (StallD),
    .FlushD        (FlushD),
    .BranchTakenE  (BranchTakenE),
    .BranchTargetE (BranchTargetE),
    .PCSrcW        (PCSrcW),
    .ResultW       (ResultW),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .PCF           (PCF),
    .InstructionD  (InstructionD),
    .PCPlus8D      (PCPlus8D),
    .ValidD        (ValidD),
    .o_state       (o_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_f(input string tag, input logic [W-1:0] pc, input logic [1:0] st);
    check({tag, ".pcf"}, PCF, pc);
    check({tag, ".addr"}, imem_addr, pc);
    check({tag, ".state"}, W'(o_state), W'(st));
  endtask

  task automatic check_d(input string tag, input logic [W-1:0] ins, input logic [W-1:0] p8,
                         input logic v);
    check({tag, ".instr"}, InstructionD, ins);
    check({tag, ".pc8"}, PCPlus8D, p8);
    check({tag, ".valid"}, W'(ValidD), W'(v));
  endtask

  initial begin
    reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    BranchTakenE = 1'b0; BranchTargetE = '0; PCSrcW = 1'b0; ResultW = '0;
    imem_ready = 1'b1;
    tick();
    tick();
    check_f("rst", 64'h0, 2'(RUN));
    check_d("rst", 64'h0, 64'h0, 1'b0);

    // Straight-line fetch
    reset = 1'b0;
    tick();
    check_f("seq1", 64'h8, 2'(RUN));
    check_d("seq1", 64'hDEAD_BEEF_0000_0000, 64'h8, 1'b1);
    tick();
    check_f("seq2", 64'h10, 2'(RUN));
    check_d("seq2", 64'hDEAD_BEEF_0000_0008, 64'h10, 1'b1);

    // Memory not ready for two cycles at PCF=16
    imem_ready = 1'b0;
    tick();
    check_f("wait1", 64'h10, 2'(WAIT));
    check_d("wait1", 64'h0, 64'h0, 1'b0);
    tick();
    check_f("wait2", 64'h10, 2'(WAIT));
    check_d("wait2", 64'h0, 64'h0, 1'b0);
    imem_ready = 1'b1;
    tick();
    check_f("resume", 64'h18, 2'(RUN));
    check_d("resume", 64'hDEAD_BEEF_0000_0010, 64'h18, 1'b1);

    // Both redirects together: Execute wins, fetched word dropped
    BranchTakenE = 1'b1; BranchTargetE = 64'h100;
    PCSrcW = 1'b1; ResultW = 64'h200;
    tick();
    check_f("both_redir", 64'h100, 2'(RUN));
    check_d("both_redir", 64'h0, 64'h0, 1'b0);
    BranchTakenE = 1'b0; PCSrcW = 1'b0;
    tick();
    check_f("after_br", 64'h108, 2'(RUN));
    check_d("after_br", 64'hDEAD_BEEF_0000_0100, 64'h108, 1'b1);

    // Writeback redirect alone
    PCSrcW = 1'b1; ResultW = 64'h200;
    tick();
    check_f("wb_redir", 64'h200, 2'(RUN));
    check_d("wb_redir", 64'h0, 64'h0, 1'b0);
    PCSrcW = 1'b0;

    // Redirect honoured under StallF
    StallF = 1'b1; BranchTakenE = 1'b1; BranchTargetE = 64'h0;
    tick();
    check_f("stall_redir", 64'h0, 2'(RUN));
    check_d("stall_redir", 64'h0, 64'h0, 1'b0);
    StallF = 1'b0; BranchTakenE = 1'b0;
    tick();
    check_f("pre_stall", 64'h8, 2'(RUN));
    check_d("pre_stall", 64'hDEAD_BEEF_0000_0000, 64'h8, 1'b1);

    // StallF+StallD hold three cycles at PCF=8, then flush
    StallF = 1'b1; StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_f("stall_hold", 64'h8, 2'(RUN));
      check_d("stall_hold", 64'hDEAD_BEEF_0000_0000, 64'h8, 1'b1);
    end
    FlushD = 1'b1;
    tick();
    check_f("flush", 64'h8, 2'(RUN));
    check_d("flush", 64'h0, 64'h0, 1'b0);
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;

    // PC wrap at top of address space
    BranchTakenE = 1'b1; BranchTargetE = 64'hFFFF_FFFF_FFFF_FFF8;
    tick();
    check_f("to_top", 64'hFFFF_FFFF_FFFF_FFF8, 2'(RUN));
    BranchTakenE = 1'b0;
    tick();
    check_f("wrap", 64'h0, 2'(RUN));
    check_d("wrap", 64'hDEAD_BEEF_FFFF_FFF8, 64'h0, 1'b1);
    tick();
    check_f("post_wrap", 64'h8, 2'(RUN));

    // Redirect while in WAIT returns to RUN
    imem_ready = 1'b0;
    tick();
    check_f("wait_a", 64'h8, 2'(WAIT));
    BranchTakenE = 1'b1; BranchTargetE = 64'h40;
    tick();
    check_f("wait_redir", 64'h40, 2'(RUN));
    check_d("wait_redir", 64'h0, 64'h0, 1'b0);
    BranchTakenE = 1'b0;
    tick();
    check_f("wait_b", 64'h40, 2'(WAIT));

    // Reset mid-WAIT overrides a redirect
    reset = 1'b1; BranchTakenE = 1'b1; BranchTargetE = 64'h300;
    tick();
    check_f("rst_wait", 64'h0, 2'(RUN));
    check_d("rst_wait", 64'h0, 64'h0, 1'b0);
    reset = 1'b0; BranchTakenE = 1'b0; imem_ready = 1'b1;
    tick();
    check_f("first_fetch", 64'h8, 2'(RUN));
    check_d("first_fetch", 64'hDEAD_BEEF_0000_0000, 64'h8, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
